// File: rtl/reg_dump.sv
// reg_dump: walks a register address range through one combinational read port
// and streams (address, value) pairs over valid/ready. Define REG_DUMP_STREAM_EN
// to prefetch the next register in HOLD and reach one word per cycle.
module reg_dump #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first,
  input  logic [ADDR_W-1:0] last,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD, FIN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] last_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              busy_q;
  logic              done_q;

  logic [ADDR_W-1:0] cur_inc;
  logic              handshake;
  logic              at_last;

  assign cur_inc   = ADDR_W'(cur_q + 1'b1);
  assign handshake = out_valid_q && out_ready;
  assign at_last   = (cur_q == last_q);

  always_comb begin
    ra = '0;
    case (state_q)
      SCAN: ra = cur_q;
`ifdef REG_DUMP_STREAM_EN
      // Prefetch the next register so a handshake can capture it on the same edge.
      HOLD: ra = at_last ? cur_q : cur_inc;
`else
      HOLD: ra = cur_q;
`endif
      default: ra = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cur_q  <= first;
            last_q <= last;
            if (first <= last) begin
              busy_q  <= 1'b1;
              state_q <= SCAN;
            end else begin
              // Empty range: complete immediately without emitting a word.
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end
        end
        SCAN: begin
          out_data_q  <= rd;
          out_addr_q  <= cur_q;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (handshake) begin
            if (at_last) begin
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= FIN;
            end else begin
              cur_q <= cur_inc;
`ifdef REG_DUMP_STREAM_EN
              out_data_q <= rd;
              out_addr_q <= cur_inc;
`else
              out_valid_q <= 1'b0;
              state_q     <= SCAN;
`endif
            end
          end
        end
        FIN: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump with a write-first register file model.
module tb_reg_dump;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
`ifdef REG_DUMP_STREAM_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  logic              clk, rst, start, out_ready, out_valid, busy, done;
  logic [ADDR_W-1:0] first, last, ra, out_addr;
  logic [DATA_W-1:0] rd, out_data;

  logic [DATA_W-1:0] regs [32];
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_word, t_prev;

  reg_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .first(first), .last(last),
    .ra(ra), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rd = (we && wa == ra) ? wd : regs[ra];
  always @(posedge clk) if (we) regs[wa] <= wd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid, then check the presented word.
  task automatic get_word(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_addr"}, out_addr, a);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_busy"}, busy, 1);
    t_prev = t_word;
    t_word = cyc;
    $display("word %s: addr=%0d data=%0h cycle=%0d", tag, out_addr, out_data, cyc);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && !done; i++) step();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_ra_at_done"}, ra, 0);
    step();
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic kick(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
    first = f; last = l; start = 1'b1;
    step();
    start = 1'b0;
    first = 5'd0; last = 5'd0;
  endtask

  initial begin
    int done_seen;
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
    regs[1] = 32'h11; regs[2] = 32'h22; regs[3] = 32'h33; regs[0] = 32'hBAD0;
    regs[31] = 32'hCAFE0031;
    we = 0; wa = 0; wd = 0;
    rst = 1; start = 0; first = 0; last = 0; out_ready = 1;
    t_word = 0; t_prev = 0;
    step(); step();
    chk("rst_valid", out_valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_ra", ra, 0); chk("rst_addr", out_addr, 0); chk("rst_data", out_data, 0);
    rst = 0;
    step();

    // Basic dump 1..3 with out_ready high.
    kick(5'd1, 5'd3);
    chk("t1_busy_e0", busy, 1); chk("t1_ra_scan", ra, 1); chk("t1_valid_e0", out_valid, 0);
    step();
    get_word("t1_w1", 5'd1, 32'h11);
    step();
    get_word("t1_w2", 5'd2, 32'h22);
    chk("t1_gap12", t_word - t_prev, GAP);
    step();
    get_word("t1_w3", 5'd3, 32'h33);
    chk("t1_gap23", t_word - t_prev, GAP);
    step();
    chk("t1_done_time", cyc - t_word, 1);
    wait_done("t1");

    // Single word at the top of the address space; no wrap to 0.
    kick(5'd31, 5'd31);
    get_word("t2_w31", 5'd31, 32'hCAFE0031);
    step();
    wait_done("t2");
    for (int i = 0; i < 3; i++) begin step(); chk("t2_no_wrap", out_valid, 0); end

    // Empty range: done straight after start, nothing emitted.
    first = 5'd5; last = 5'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_done", done, 1); chk("t3_busy", busy, 0); chk("t3_valid", out_valid, 0);
    step();
    chk("t3_done_clear", done, 0);
    for (int i = 0; i < 3; i++) begin step(); chk("t3_valid_never", out_valid, 0); end

    // Backpressure on register 2; source value changes must not leak through.
    kick(5'd1, 5'd3);
    get_word("t4_w1", 5'd1, 32'h11);
    step();
    out_ready = 0;
    get_word("t4_w2", 5'd2, 32'h22);
    regs[2] = 32'h99;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_stall_valid", out_valid, 1);
      chk("t4_stall_addr", out_addr, 2);
      chk("t4_stall_data", out_data, 32'h22);
    end
    regs[2] = 32'h22;
    out_ready = 1;
    step();
    get_word("t4_w3", 5'd3, 32'h33);
    step();
    wait_done("t4");

    // Write-first capture on the edge register 4 is sampled.
    first = 5'd4; last = 5'd4; start = 1'b1;
    step();
    start = 1'b0;
    we = 1; wa = 5'd4; wd = 32'hDEAD;
    step();
    we = 0;
    get_word("t5_w4", 5'd4, 32'hDEAD);
    step();
    wait_done("t5");

    // Reset after the second word: async clear, no done, clean restart.
    kick(5'd1, 5'd3);
    get_word("t6_w1", 5'd1, 32'h11);
    step();
    get_word("t6_w2", 5'd2, 32'h22);
    step();
    rst = 1;
    #1;
    chk("t6_rst_valid", out_valid, 0); chk("t6_rst_busy", busy, 0); chk("t6_rst_done", done, 0);
    chk("t6_rst_ra", ra, 0); chk("t6_rst_addr", out_addr, 0); chk("t6_rst_data", out_data, 0);
    step();
    rst = 0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin step(); if (done) done_seen++; end
    chk("t6_no_done", done_seen, 0);
    kick(5'd6, 5'd7);
    get_word("t6_w6", 5'd6, 32'h106);
    step();
    get_word("t6_w7", 5'd7, 32'h107);
    step();
    wait_done("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
